biquad_cascade: RTL

BIQUAD_CASCADE -- requirements
Module: biquad_cascade

---
 rtl/biquad_cascade.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/biquad_cascade.sv
// Cascade of Direct Form I biquad sections sharing one multiplier.
// Each stage takes 5 MAC cycles plus 1 store cycle; coefficient stage*5+k is b0,b1,b2,a1,a2.
module biquad_cascade #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4,
  parameter int FRAC   = 14
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [WIDTH-1:0]        x,
  input  logic                           coef_we,
  input  logic [$clog2(5*STAGES)-1:0]    coef_addr,
  input  logic signed [WIDTH-1:0]        coef_data,
  input  logic                           clear,
  output logic                           out_valid,
  output logic signed [WIDTH-1:0]        y
);

  localparam int NCOEF = 5 * STAGES;
  localparam int AW    = $clog2(NCOEF);
  localparam int SW    = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int PW    = 2 * WIDTH;
  localparam int ACCW  = 2 * WIDTH + 3;

  localparam logic signed [ACCW-1:0] HALF = ACCW'(1) <<< (FRAC - 1);
  localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV = {{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, STORE = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              k_q, k_d;
  logic [SW-1:0]           stage_q, stage_d;
  logic signed [WIDTH-1:0] cur_in_q, cur_in_d;
  logic signed [ACCW-1:0]  acc_q, acc_d;
  logic signed [WIDTH-1:0] y_q, y_d;
  logic                    out_valid_q, out_valid_d;

  logic signed [WIDTH-1:0] coef_q [NCOEF];
  logic signed [WIDTH-1:0] coef_d [NCOEF];
  logic signed [WIDTH-1:0] x1_q [STAGES];
  logic signed [WIDTH-1:0] x1_d [STAGES];
  logic signed [WIDTH-1:0] x2_q [STAGES];
  logic signed [WIDTH-1:0] x2_d [STAGES];
  logic signed [WIDTH-1:0] y1_q [STAGES];
  logic signed [WIDTH-1:0] y1_d [STAGES];
  logic signed [WIDTH-1:0] y2_q [STAGES];
  logic signed [WIDTH-1:0] y2_d [STAGES];

  logic [AW-1:0]           coef_idx;
  logic signed [WIDTH-1:0] mul_a;
  logic signed [WIDTH-1:0] mul_b;
  logic signed [PW-1:0]    prod;
  logic signed [ACCW-1:0]  prod_ext;
  logic signed [ACCW-1:0]  acc_base;
  logic signed [ACCW-1:0]  acc_rnd;
  logic signed [ACCW-1:0]  acc_shr;
  logic signed [WIDTH-1:0] sat;

  assign coef_idx = AW'(int'(stage_q) * 5 + int'(k_q));
  assign mul_b    = coef_q[coef_idx];
  assign prod     = mul_a * mul_b;
  assign prod_ext = ACCW'(prod);
  assign acc_base = (k_q == 3'd0) ? '0 : acc_q;
  assign acc_rnd  = acc_q + HALF;
  assign acc_shr  = acc_rnd >>> FRAC;

  always_comb begin
    case (k_q)
      3'd1:    mul_a = x1_q[stage_q];
      3'd2:    mul_a = x2_q[stage_q];
      3'd3:    mul_a = y1_q[stage_q];
      3'd4:    mul_a = y2_q[stage_q];
      default: mul_a = cur_in_q;
    endcase
  end

  always_comb begin
    if (acc_shr > MAXV)      sat = MAXV[WIDTH-1:0];
    else if (acc_shr < MINV) sat = MINV[WIDTH-1:0];
    else                     sat = acc_shr[WIDTH-1:0];
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    stage_d     = stage_q;
    cur_in_d    = cur_in_q;
    acc_d       = acc_q;
    y_d         = y_q;
    out_valid_d = 1'b0;
    coef_d      = coef_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    case (state_q)
      IDLE: begin
        // Clear and coefficient update land on the same edge as acceptance,
        // so an accepted sample sees both.
        if (clear) begin
          x1_d = '{default: '0};
          x2_d = '{default: '0};
          y1_d = '{default: '0};
          y2_d = '{default: '0};
        end
        if (coef_we && (int'(coef_addr) < NCOEF)) coef_d[coef_addr] = coef_data;
        if (in_valid) begin
          cur_in_d = x;
          stage_d  = '0;
          k_d      = '0;
          state_d  = MAC;
        end
      end
      MAC: begin
        acc_d = (k_q >= 3'd3) ? (acc_base - prod_ext) : (acc_base + prod_ext);
        if (k_q == 3'd4) begin
          k_d     = '0;
          state_d = STORE;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      STORE: begin
        x2_d[stage_q] = x1_q[stage_q];
        x1_d[stage_q] = cur_in_q;
        y2_d[stage_q] = y1_q[stage_q];
        y1_d[stage_q] = sat;
        cur_in_d      = sat;
        if (stage_q == SW'(STAGES - 1)) begin
          y_d         = sat;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          stage_d = stage_q + SW'(1);
          state_d = MAC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      stage_q     <= '0;
      cur_in_q    <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      coef_q      <= '{default: '0};
      x1_q        <= '{default: '0};
      x2_q        <= '{default: '0};
      y1_q        <= '{default: '0};
      y2_q        <= '{default: '0};
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      stage_q     <= stage_d;
      cur_in_q    <= cur_in_d;
      acc_q       <= acc_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      coef_q      <= coef_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign y         = y_q;

endmodule
